// File: rtl/dma_pkg.sv
// Shared constants, FSM states and DMA word packing for the DMA lane sequencer.
package dma_pkg;

    localparam int NUM_LANES = 18;
    localparam int DATA_W    = 25;
    localparam int ROWS_W    = 16;
    localparam int PAY_LSB   = 7;
    localparam int VLD_BIT   = 6;
    localparam int EOR_BIT   = 5;

    localparam logic [4:0]  IDX_IDLE  = 5'd31;
    localparam logic [4:0]  IDX_LAST  = 5'(NUM_LANES - 1);
    localparam logic [31:0] IDLE_WORD = {25'd0, 1'b0, 1'b0, IDX_IDLE};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    function automatic logic [31:0] pack_word(input logic [DATA_W-1:0] pay,
                                              input logic              vld,
                                              input logic              eor,
                                              input logic [4:0]        idx);
        logic [31:0] w;
        w               = '0;
        w[31:PAY_LSB]   = pay;
        w[VLD_BIT]      = vld;
        w[EOR_BIT]      = eor;
        w[4:0]          = idx;
        return w;
    endfunction

endpackage

// File: rtl/dma_lane_sequencer_if.sv
// Payload stream and DMA port bundle; the sequencer is the slave side.
interface dma_lane_sequencer_if;
    import dma_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              dma_ready;
    logic [31:0]       dma_word;

    modport master (output s_data, s_valid, s_last, dma_ready,
                    input  s_ready, dma_word);
    modport slave  (input  s_data, s_valid, s_last, dma_ready,
                    output s_ready, dma_word);
endinterface

// File: rtl/dma_skid_buffer.sv
// Two-entry FIFO holding {last, payload}; head always at mem0.
module dma_skid_buffer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem0_q, mem1_q;
    logic [1:0]       cnt_q;
    logic             wr_sel;

    // A push lands in the first free slot as seen after this cycle's pop.
    assign wr_sel = (cnt_q - {1'b0, pop}) != 2'd0;

    always_ff @(posedge clk) begin
        if (pop)
            mem0_q <= mem1_q;
        if (push) begin
            if (wr_sel)
                mem1_q <= din;
            else
                mem0_q <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 2'd0;
        else
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end

    assign dout  = mem0_q;
    assign count = cnt_q;
endmodule

// File: rtl/dma_lane_sequencer.sv
// Tags payloads with a rotating lane index, pads short rounds with zero
// words and frames the stream by cfg_rows rounds or s_last.
module dma_lane_sequencer
    import dma_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROWS_W-1:0]  cfg_rows,
    dma_lane_sequencer_if.slave bus,
    output logic               busy,
    output logic               done
);
    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d, in_idx_q, in_idx_d;
    logic [ROWS_W-1:0] row_q, row_d, rows_q, rows_d, in_row_q, in_row_d;
    logic              in_end_q, in_end_d, ready_q, ready_d, busy_q, done_q;
    logic [31:0]       word_q, word_d;
    logic              in_fire, buf_empty, have, issue, push, pop;
    logic [1:0]        buf_cnt, cnt_nx;
    logic [DATA_W:0]   buf_dout, src;

    // An empty buffer is bypassed so an accepted payload issues the same cycle.
    assign in_fire   = bus.s_valid && ready_q;
    assign buf_empty = (buf_cnt == 2'd0);
    assign src       = buf_empty ? {bus.s_last, bus.s_data} : buf_dout;
    assign have      = !buf_empty || in_fire;
    assign push      = in_fire && !(issue && buf_empty);
    assign pop       = issue && !buf_empty;
    assign cnt_nx    = buf_cnt + {1'b0, push} - {1'b0, pop};

    dma_skid_buffer #(.WIDTH(DATA_W + 1)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.s_last, bus.s_data}),
        .dout  (buf_dout),
        .count (buf_cnt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        rows_d   = rows_q;
        in_idx_d = in_idx_q;
        in_row_d = in_row_q;
        in_end_d = in_end_q;
        word_d   = IDLE_WORD;
        issue    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                rows_d   = cfg_rows;
                idx_d    = '0;
                row_d    = '0;
                in_idx_d = '0;
                in_row_d = '0;
                in_end_d = 1'b0;
                state_d  = (cfg_rows == '0) ? DONE : RUN;
            end
            RUN: if (have && bus.dma_ready) begin
                issue  = 1'b1;
                word_d = pack_word(src[DATA_W-1:0], 1'b1, idx_q == IDX_LAST, idx_q);
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    row_d = row_q + ROWS_W'(1);
                    if (src[DATA_W] || (row_q + ROWS_W'(1) == rows_q))
                        state_d = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                    if (src[DATA_W])
                        state_d = FLUSH;
                end
            end
            FLUSH: if (bus.dma_ready) begin
                word_d = pack_word('0, 1'b1, idx_q == IDX_LAST, idx_q);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Input-side slot tracking closes s_ready once the frame's last slot is taken.
        if (in_fire) begin
            if (bus.s_last || (in_idx_q == IDX_LAST && in_row_q + ROWS_W'(1) == rows_q))
                in_end_d = 1'b1;
            if (in_idx_q == IDX_LAST) begin
                in_idx_d = '0;
                in_row_d = in_row_q + ROWS_W'(1);
            end else begin
                in_idx_d = in_idx_q + 5'd1;
            end
        end
        ready_d = (state_d == RUN) && !in_end_d && (cnt_nx != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            row_q    <= '0;
            rows_q   <= '0;
            in_idx_q <= '0;
            in_row_q <= '0;
            in_end_q <= 1'b0;
            ready_q  <= 1'b0;
            word_q   <= IDLE_WORD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            rows_q   <= rows_d;
            in_idx_q <= in_idx_d;
            in_row_q <= in_row_d;
            in_end_q <= in_end_d;
            ready_q  <= ready_d;
            word_q   <= word_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_q == DONE);
        end
    end

    assign bus.s_ready  = ready_q;
    assign bus.dma_word = word_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_dma_lane_sequencer.sv
// Scoreboard bench for dma_lane_sequencer: expected DMA words are queued with the stimulus.
module tb_dma_lane_sequencer;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_rows;
    logic        busy, done;
    int          chk_cnt, pass_cnt;
    logic [25:0] src_q[$];
    logic [31:0] exp_q[$];

    dma_lane_sequencer_if bus ();

    dma_lane_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_rows (cfg_rows),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [24:0] p, input logic [4:0] k);
        return {p, 1'b1, (k == 5'd17), k};
    endfunction

    // One clock: drive from the source queue, sample at negedge, retire accepted payloads.
    task automatic cyc(input logic rdy, output logic [31:0] w, output logic acc,
                       output logic dn, output logic bz, output logic rd);
        bus.dma_ready = rdy;
        if (src_q.size() > 0) begin
            bus.s_valid = 1'b1;
            {bus.s_last, bus.s_data} = src_q[0];
        end else begin
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            bus.s_data  = '0;
        end
        @(negedge clk);
        w   = bus.dma_word;
        rd  = bus.s_ready;
        acc = bus.s_valid && bus.s_ready;
        dn  = done;
        bz  = busy;
        @(posedge clk);
        #1;
        if (acc) void'(src_q.pop_front());
    endtask

    task automatic do_start(input logic [15:0] rows);
        start    = 1'b1;
        cfg_rows = rows;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if (bus.dma_word !== 32'h0000_001F) $display("FAIL reset_word: got %h, required %h", bus.dma_word, 32'h1F);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.s_ready, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got ready/busy/done=%b, required 000", {bus.s_ready, busy, done});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.dma_word !== 32'h0000_001F || bus.s_ready !== 1'b0) $display("FAIL post_reset_idle: got word=%h ready=%b, required 1f/0", bus.dma_word, bus.s_ready);
        else pass_cnt++;
    endtask

    task automatic test_single_round();
        logic [31:0] w, e;
        logic acc, dn, bz, rd;
        int first_acc, first_vld, last_vld, done_cyc;
        src_q.delete(); exp_q.delete();
        for (int k = 0; k < 18; k++) begin
            src_q.push_back({1'b0, 25'(k + 1)});
            exp_q.push_back(mk(25'(k + 1), 5'(k)));
        end
        do_start(16'd1);
        first_acc = -1; first_vld = -1; last_vld = -1; done_cyc = -1;
        for (int i = 0; i < 60 && done_cyc < 0; i++) begin
            cyc(1'b1, w, acc, dn, bz, rd);
            if (acc && first_acc < 0) first_acc = i;
            if (w[6]) begin
                if (first_vld < 0) first_vld = i;
                last_vld = i;
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL single_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL single_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
            if (dn) begin
                done_cyc = i;
                chk_cnt++;
                if (w !== 32'h1F || bz !== 1'b0) $display("FAIL single_done_state: got word=%h busy=%b, required 1f/0", w, bz);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (done_cyc !== last_vld + 1 || done_cyc < 0) $display("FAIL single_done_cycle: got %0d, required %0d", done_cyc, last_vld + 1);
        else pass_cnt++;
        chk_cnt++;
        if (first_vld !== first_acc + 1 || first_acc < 0) $display("FAIL single_latency: got first word cycle %0d, required %0d", first_vld, first_acc + 1);
        else pass_cnt++;
        chk_cnt++;
        if (last_vld - first_vld !== 17 || exp_q.size() !== 0) $display("FAIL single_contiguous: got span %0d left %0d, required 17/0", last_vld - first_vld, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_early_last();
        logic [31:0] w, e;
        logic acc, dn, bz, rd;
        int last_vld, done_cyc;
        src_q.delete(); exp_q.delete();
        for (int k = 1; k <= 21; k++) src_q.push_back({(k == 20), 25'(k)});
        for (int k = 0; k < 18; k++) exp_q.push_back(mk(25'(k + 1), 5'(k)));
        exp_q.push_back(mk(25'd19, 5'd0));
        exp_q.push_back(mk(25'd20, 5'd1));
        for (int k = 2; k < 18; k++) exp_q.push_back(mk(25'd0, 5'(k)));
        do_start(16'd4);
        last_vld = -1; done_cyc = -1; rd = 1'b0;
        for (int i = 0; i < 100 && done_cyc < 0; i++) begin
            cyc(1'b1, w, acc, dn, bz, rd);
            if (w[6]) begin
                last_vld = i;
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL last_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL last_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
            if (dn) done_cyc = i;
        end
        chk_cnt++;
        if (done_cyc !== last_vld + 1 || done_cyc < 0) $display("FAIL last_done_cycle: got %0d, required %0d", done_cyc, last_vld + 1);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL last_flush_count: got %0d words missing, required 0", exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (src_q.size() !== 1 || rd !== 1'b0) $display("FAIL last_no_accept: got %0d left ready=%b, required 1/0", src_q.size(), rd);
        else pass_cnt++;
        src_q.delete();
    endtask

    task automatic test_ready_toggle();
        logic [31:0] w, e;
        logic acc, dn, bz, rd, rdy, prev_rdy;
        int done_cyc;
        src_q.delete(); exp_q.delete();
        for (int k = 0; k < 18; k++) begin
            src_q.push_back({1'b0, 25'(100 + k)});
            exp_q.push_back(mk(25'(100 + k), 5'(k)));
        end
        do_start(16'd1);
        prev_rdy = 1'b0; done_cyc = -1;
        for (int i = 0; i < 120 && done_cyc < 0; i++) begin
            rdy = (i % 2 == 0);
            cyc(rdy, w, acc, dn, bz, rd);
            if (!prev_rdy) begin
                chk_cnt++;
                if (w !== 32'h1F) $display("FAIL toggle_idle: cycle %0d got %h, required %h", i, w, 32'h1F);
                else pass_cnt++;
            end else if (w[6]) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL toggle_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL toggle_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
            prev_rdy = rdy;
            if (dn) done_cyc = i;
        end
        chk_cnt++;
        if (done_cyc < 0 || exp_q.size() !== 0) $display("FAIL toggle_complete: got done=%0d left=%0d, required done seen and 0 left", done_cyc, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_zero_rows();
        logic [31:0] w;
        logic acc, dn, bz, rd, saw_ready;
        int done_cyc, done_n;
        src_q.delete(); exp_q.delete();
        src_q.push_back({1'b0, 25'h1ABCDE});
        src_q.push_back({1'b1, 25'h0000AA});
        do_start(16'd0);
        done_cyc = -1; done_n = 0; saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, w, acc, dn, bz, rd);
            if (rd) saw_ready = 1'b1;
            if (dn) begin
                done_n++;
                if (done_cyc < 0) done_cyc = i;
            end
            if (i == 0) begin
                chk_cnt++;
                if (bz !== 1'b1) $display("FAIL zero_busy: got %b, required 1", bz);
                else pass_cnt++;
            end
            chk_cnt++;
            if (w !== 32'h1F) $display("FAIL zero_word: cycle %0d got %h, required %h", i, w, 32'h1F);
            else pass_cnt++;
        end
        chk_cnt++;
        if (done_cyc !== 1 || done_n !== 1) $display("FAIL zero_done: got cycle %0d count %0d, required 1/1", done_cyc, done_n);
        else pass_cnt++;
        chk_cnt++;
        if (saw_ready !== 1'b0 || src_q.size() !== 2) $display("FAIL zero_ready: got ready seen=%b left=%0d, required 0/2", saw_ready, src_q.size());
        else pass_cnt++;
        src_q.delete();
    endtask

    task automatic test_reset_mid_round();
        logic [31:0] w, e;
        logic acc, dn, bz, rd, seen9;
        int low_n, done_cyc;
        src_q.delete(); exp_q.delete();
        for (int k = 0; k < 18; k++) begin
            src_q.push_back({1'b0, 25'(50 + k)});
            exp_q.push_back(mk(25'(50 + k), 5'(k)));
        end
        do_start(16'd1);
        seen9 = 1'b0; low_n = 0;
        for (int i = 0; i < 60 && low_n < 3; i++) begin
            cyc(!seen9, w, acc, dn, bz, rd);
            if (seen9) low_n++;
            if (w[6]) begin
                if (w[4:0] == 5'd9) seen9 = 1'b1;
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL pre_reset_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL pre_reset_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
        end
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (bus.dma_word !== 32'h1F || {bus.s_ready, busy, done} !== 3'b000)
            $display("FAIL mid_reset: got word=%h ready/busy/done=%b, required 1f/000", bus.dma_word, {bus.s_ready, busy, done});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete(); exp_q.delete();
        bus.s_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            src_q.push_back({1'b0, 25'(200 + k)});
            exp_q.push_back(mk(25'(200 + k), 5'(k)));
        end
        do_start(16'd1);
        done_cyc = -1;
        for (int i = 0; i < 60 && done_cyc < 0; i++) begin
            cyc(1'b1, w, acc, dn, bz, rd);
            if (w[6]) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL restart_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL restart_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
            if (dn) done_cyc = i;
        end
        chk_cnt++;
        if (done_cyc < 0 || exp_q.size() !== 0) $display("FAIL restart_complete: got done=%0d left=%0d, required done seen and 0 left", done_cyc, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_skid_backpressure();
        logic [31:0] w, e;
        logic acc, dn, bz, rd;
        int acc_n, v0, v1, done_cyc;
        src_q.delete(); exp_q.delete();
        for (int k = 0; k < 18; k++) begin
            src_q.push_back({1'b0, 25'(300 + k)});
            exp_q.push_back(mk(25'(300 + k), 5'(k)));
        end
        do_start(16'd1);
        acc_n = 0; v0 = -1; v1 = -1; done_cyc = -1;
        for (int i = 0; i < 80 && done_cyc < 0; i++) begin
            cyc(i >= 5, w, acc, dn, bz, rd);
            if (i < 5 && acc) acc_n++;
            if (i == 4) begin
                chk_cnt++;
                if (rd !== 1'b0 || acc_n !== 2) $display("FAIL skid_fill: got ready=%b accepts=%0d, required 0/2", rd, acc_n);
                else pass_cnt++;
            end
            if (w[6]) begin
                if (v0 < 0) v0 = i;
                else if (v1 < 0) v1 = i;
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL skid_word: got %h, required no valid word", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL skid_word: got %h, required %h", w, e);
                    else pass_cnt++;
                end
            end
            if (dn) done_cyc = i;
        end
        chk_cnt++;
        if (v0 !== 6 || v1 !== 7) $display("FAIL skid_release: got words at %0d,%0d, required 6,7", v0, v1);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc < 0 || exp_q.size() !== 0) $display("FAIL skid_complete: got done=%0d left=%0d, required done seen and 0 left", done_cyc, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        rst = 1'b1; start = 1'b0; cfg_rows = '0;
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.dma_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_round();
        test_early_last();
        test_ready_toggle();
        test_zero_rows();
        test_reset_mid_round();
        test_skid_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
